axis2bram_capture: RTL and testbench
====================================

# axis2bram_capture

Stream-to-BRAM capture stage placed directly upstream of the BRAM master port. It accepts one AXI4-Stream frame per `start` command and writes its beats to consecutive BRAM word addresses from 0. It uses `s_axis_tkeep` as the byte write enables. It reports the captured beat count, a completion pulse and a sticky overflow flag, and drives the standard Xilinx BRAM interface toward a block-memory generator or BRAM controller port.

## Interface
- `MEM_WIDTH`, default 64: data width in bits; must be a multiple of 8.
- `MEM_SIZE`, default 1024: depth in words; must be a power of two, ≥ 2. Define `AW = $clog2(MEM_SIZE)`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle command: arm a capture (honoured in IDLE only).
- `abort`  in  1  one-cycle command: stop capture immediately.
- `s_axis_tdata`  in  MEM_WIDTH  stream data.
- `s_axis_tkeep`  in  MEM_WIDTH/8  byte qualifiers; these become `bram_we`.
- `s_axis_tlast`  in  1  end of frame.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when `tvalid && tready`.
- `bram_en`  out  1  BRAM enable.
- `bram_we`  out  MEM_WIDTH/8  byte write enables.
- `bram_addr`  out  AW  word address.
- `bram_din`  out  MEM_WIDTH  write data.
- `bram_dout`  in  MEM_WIDTH  read data; unused, present for interface completeness.
- `bram_clk`  out  1  equals `clk`.
- `bram_rst`  out  1  equals `rst`.
- `busy`  out  1  high in CAPTURE and DISCARD.
- `done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky: the frame exceeded MEM_SIZE beats.
- `count`  out  AW+1  beats written in the current or last capture, range 0..MEM_SIZE.

## Operation
States:
- **IDLE**
  - `tready=0`.
  - `start && !abort` → CAPTURE.
  - On that transition: clear `count` and `overflow`, and set the write pointer to 0.
- **CAPTURE**
  - `tready=1`.
  - Each accepted beat: write to `addr = ptr`, then `ptr++` and `count++`.
  - Accepted beat with `tlast` → DONE.
  - Accepted beat without `tlast` when `count` reaches MEM_SIZE (the beat was written at address MEM_SIZE-1) → DISCARD, and set `overflow=1`.
- **DISCARD**
  - `tready=1`.
  - Beats are dropped; `bram_en=0`.
  - Accepted beat with `tlast` → DONE.
- **DONE**
  - `tready=0`, `done=1` for exactly one cycle, then → IDLE.
  - `start` is ignored in this state.

Rules:
- `abort` in CAPTURE or DISCARD → IDLE next cycle. No `done` pulse. `count` and `overflow` keep their values. A beat accepted in the same cycle as `abort` is still written.
- `abort` and `start` together in IDLE: `abort` wins, stay in IDLE.
- `start` in any state other than IDLE is ignored.
- A beat with `tkeep=0` is accepted and counted; it produces `bram_en=1` with `bram_we=0`.
- The write pointer never wraps. Address MEM_SIZE-1 is the last address written.
- A `tlast` on exactly the MEM_SIZE-th beat is a normal completion: `overflow=0`, `count=MEM_SIZE`.

## Timing
- Every BRAM output except `bram_clk` and `bram_rst` is registered.
- A beat accepted in cycle N appears on `bram_en`/`bram_we`/`bram_addr`/`bram_din` in cycle N+1 for exactly one cycle. `bram_en=0` and `bram_we=0` in every cycle with no write.
- `s_axis_tready` is a registered function of state, with no combinational path from `tvalid`. Throughput is one beat per cycle.
- `count` updates in cycle N+1 for a beat accepted in cycle N.
- If the `tlast` beat is accepted in cycle N, then in cycle N+1 the state is DONE, `done=1`, the final write is on the BRAM port and `count` is final. The state is IDLE in cycle N+2.
- `busy` goes high the cycle after `start` and goes low in the DONE cycle or the cycle after `abort`.
- Reset values:
  - `tready`, `busy`, `done`, `overflow`, `bram_en`, `bram_we`: 0.
  - `bram_addr`, `bram_din`, `count`: 0.
  - State: IDLE.
- `rst` asserted mid-capture returns the block to these values immediately. The partially written frame stays in BRAM.

## Test plan
- **Basic frame.** `start`, then 4 beats with data 0x11..0x44, `tkeep=0xFF`, `tlast` on the 4th.
  - Writes appear at addr 0..3 with `we=0xFF` and the matching data.
  - `done` pulses one cycle after the 4th beat; `count=4`, `overflow=0`.
- **Backpressure-free gaps.** Same frame with `tvalid` toggled 1,0,1,1,0,1.
  - No write occurs in gap cycles; addresses stay contiguous 0..3; `count=4`.
- **Exact fill.** MEM_SIZE=16, 16 beats with `tlast` on the 16th.
  - The last write is at addr 15; `count=16`, `overflow=0`, `done` pulses.
- **Overflow.** MEM_SIZE=16, 20 beats with `tlast` on the 20th.
  - Writes go to addr 0..15 only; beats 17–20 are accepted without any BRAM write.
  - `overflow=1`, `count=16`, `done` one cycle after beat 20.
- **Partial keep and abort.** Beat 0 with `tkeep=0x0F`, beat 1 with `tkeep=0x00`, then `abort` asserted alongside beat 2.
  - Writes: `we=0x0F` at addr 0, `we=0` at addr 1, beat 2 written at addr 2.
  - No `done` pulse; `count=3`; state returns to IDLE.
- **Async reset mid-frame.** Assert `rst` after 2 beats.
  - All outputs drop to their reset values without waiting for a clock edge.
  - A new `start` followed by a 1-beat frame writes addr 0 with `count=1`.

Source files
------------

// File: rtl/axis2bram_capture_if.sv
// AXI4-Stream beat channel feeding the capture stage.
// The master drives data/qualifiers and the slave returns tready.
interface axis2bram_capture_if #(
    parameter int unsigned MEM_WIDTH = 64
);
    logic [MEM_WIDTH-1:0]   tdata;
    logic [MEM_WIDTH/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis2bram_capture.sv
// Captures one AXI4-Stream frame per start command into BRAM words 0.. with tkeep as byte enables.
// Beats past the memory depth are drained without writing and flagged as overflow.
module axis2bram_capture #(
    parameter int unsigned MEM_WIDTH = 64,
    parameter int unsigned MEM_SIZE  = 1024,
    localparam int unsigned AW       = $clog2(MEM_SIZE),
    localparam int unsigned KW       = MEM_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    axis2bram_capture_if.slave     s_axis,
    output logic                   bram_en,
    output logic [KW-1:0]          bram_we,
    output logic [AW-1:0]          bram_addr,
    output logic [MEM_WIDTH-1:0]   bram_din,
    input  logic [MEM_WIDTH-1:0]   bram_dout,
    output logic                   bram_clk,
    output logic                   bram_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [AW:0]            count
);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDiscard,
        StDone
    } state_e;

    // Count value just before the beat that lands on the last address.
    localparam logic [AW:0] LastCount = (AW+1)'(MEM_SIZE - 1);

    state_e                 state_q, state_d;
    logic                   tready_q, tready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   bram_en_q;
    logic [KW-1:0]          bram_we_q;
    logic [AW-1:0]          bram_addr_q;
    logic [MEM_WIDTH-1:0]   bram_din_q;

    logic accept;
    logic wr;
    logic full;
    logic arm;

    assign accept = s_axis.tvalid && tready_q;
    assign wr     = accept && (state_q == StCapture);
    assign full   = (count_q == LastCount);
    assign arm    = (state_q == StIdle) && start && !abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept) begin
                    if (s_axis.tlast) begin
                        state_d = StDone;
                    end else if (full) begin
                        state_d = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (accept && s_axis.tlast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs are registered copies of the upcoming state's decode,
    // so they line up with state_q without any path from tvalid.
    always_comb begin
        tready_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            StCapture, StDiscard: begin
                tready_d = 1'b1;
                busy_d   = 1'b1;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                tready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Pointer, beat count and overflow flag
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (arm) begin
            ptr_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
        if (wr) begin
            ptr_d   = ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(1);
            if (!s_axis.tlast && !abort && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // BRAM write port; address and data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_en_q <= wr;
            bram_we_q <= wr ? s_axis.tkeep : '0;
            if (wr) begin
                bram_addr_q <= ptr_q;
                bram_din_q  <= s_axis.tdata;
            end
        end
    end

    logic unused_dout;
    assign unused_dout = ^bram_dout;

    assign s_axis.tready = tready_q;
    assign bram_en       = bram_en_q;
    assign bram_we       = bram_we_q;
    assign bram_addr     = bram_addr_q;
    assign bram_din      = bram_din_q;
    assign bram_clk      = clk;
    assign bram_rst      = rst;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign count         = count_q;

endmodule

// File: tb/tb_axis2bram_capture.sv
// Directed bench for axis2bram_capture with a 16-word, 64-bit memory.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_axis2bram_capture;

    localparam int unsigned W  = 64;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned KW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          bram_en;
    logic [KW-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_din;
    logic [W-1:0]  bram_dout;
    logic          bram_clk;
    logic          bram_rst;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;

    axis2bram_capture_if #(.MEM_WIDTH(W)) s_axis_if ();

    axis2bram_capture #(
        .MEM_WIDTH (W),
        .MEM_SIZE  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_axis    (s_axis_if),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .bram_clk  (bram_clk),
        .bram_rst  (bram_rst),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .count     (count)
    );

    assign bram_dout = '0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = d;
        s_axis_if.tkeep  = k;
        s_axis_if.tlast  = l;
        tick();
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] a, input logic [63:0] d,
                          input logic [7:0] k);
        chk({tag, ".en"},   64'(bram_en),   64'd1);
        chk({tag, ".addr"}, 64'(bram_addr), 64'(a));
        chk({tag, ".din"},  64'(bram_din),  d);
        chk({tag, ".we"},   64'(bram_we),   64'(k));
    endtask

    task automatic chk_nowr(input string tag);
        chk({tag, ".en"}, 64'(bram_en), 64'd0);
        chk({tag, ".we"}, 64'(bram_we), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".tready"},   64'(s_axis_if.tready), 64'd0);
        chk({tag, ".busy"},     64'(busy),             64'd0);
        chk({tag, ".done"},     64'(done),             64'd0);
        chk({tag, ".overflow"}, 64'(overflow),         64'd0);
        chk({tag, ".en"},       64'(bram_en),          64'd0);
        chk({tag, ".we"},       64'(bram_we),          64'd0);
        chk({tag, ".addr"},     64'(bram_addr),        64'd0);
        chk({tag, ".din"},      64'(bram_din),         64'd0);
        chk({tag, ".count"},    64'(count),            64'd0);
    endtask

    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tkeep  = '0;
        #1;
        chk_reset_vals("por");
        chk("por.bram_rst", 64'(bram_rst), 64'd1);
        tick();
        tick();
        rst = 1'b0;

        // Basic frame
        arm();
        chk("basic.busy", 64'(busy), 64'd1);
        chk("basic.tready", 64'(s_axis_if.tready), 64'd1);
        beat(64'h11, 8'hFF, 1'b0);
        chk_wr("basic.b0", 4'd0, 64'h11, 8'hFF);
        chk("basic.count1", 64'(count), 64'd1);
        beat(64'h22, 8'hFF, 1'b0);
        chk_wr("basic.b1", 4'd1, 64'h22, 8'hFF);
        beat(64'h33, 8'hFF, 1'b0);
        chk_wr("basic.b2", 4'd2, 64'h33, 8'hFF);
        beat(64'h44, 8'hFF, 1'b1);
        chk_wr("basic.b3", 4'd3, 64'h44, 8'hFF);
        chk("basic.done", 64'(done), 64'd1);
        chk("basic.count", 64'(count), 64'd4);
        chk("basic.ovf", 64'(overflow), 64'd0);
        chk("basic.busy_done", 64'(busy), 64'd0);
        chk("basic.tready_done", 64'(s_axis_if.tready), 64'd0);
        tick();
        chk("basic.done_end", 64'(done), 64'd0);
        chk_nowr("basic.after");

        // Gapped valid 1,0,1,1,0,1
        arm();
        beat(64'h11, 8'hFF, 1'b0);
        chk_wr("gap.b0", 4'd0, 64'h11, 8'hFF);
        tick();
        chk_nowr("gap.g0");
        beat(64'h22, 8'hFF, 1'b0);
        chk_wr("gap.b1", 4'd1, 64'h22, 8'hFF);
        beat(64'h33, 8'hFF, 1'b0);
        chk_wr("gap.b2", 4'd2, 64'h33, 8'hFF);
        tick();
        chk_nowr("gap.g1");
        chk("gap.count_mid", 64'(count), 64'd3);
        beat(64'h44, 8'hFF, 1'b1);
        chk_wr("gap.b3", 4'd3, 64'h44, 8'hFF);
        chk("gap.done", 64'(done), 64'd1);
        chk("gap.count", 64'(count), 64'd4);
        // start during DONE is ignored
        arm();
        chk("gap.start_in_done", 64'(busy), 64'd0);
        chk("gap.done_end", 64'(done), 64'd0);
        tick();
        chk("gap.still_idle", 64'(busy), 64'd0);

        // Exact fill
        arm();
        for (int i = 0; i < 16; i++) begin
            beat(64'h100 + 64'(i), 8'hFF, i == 15);
            chk_wr("fill", 4'(i), 64'h100 + 64'(i), 8'hFF);
        end
        chk("fill.done", 64'(done), 64'd1);
        chk("fill.count", 64'(count), 64'd16);
        chk("fill.ovf", 64'(overflow), 64'd0);
        tick();

        // Overflow: 20 beats into 16 words
        arm();
        for (int i = 0; i < 20; i++) begin
            beat(64'h200 + 64'(i), 8'hFF, i == 19);
            if (i < 16) begin
                chk_wr("ovf.wr", 4'(i), 64'h200 + 64'(i), 8'hFF);
            end else begin
                chk_nowr("ovf.drop");
                chk("ovf.count_hold", 64'(count), 64'd16);
            end
            if (i == 15) begin
                chk("ovf.flag", 64'(overflow), 64'd1);
                chk("ovf.busy", 64'(busy), 64'd1);
                chk("ovf.tready", 64'(s_axis_if.tready), 64'd1);
            end
        end
        chk("ovf.done", 64'(done), 64'd1);
        chk("ovf.count", 64'(count), 64'd16);
        chk("ovf.sticky", 64'(overflow), 64'd1);
        tick();
        chk("ovf.sticky_idle", 64'(overflow), 64'd1);

        // start with abort in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa.busy", 64'(busy), 64'd0);
        chk("sa.tready", 64'(s_axis_if.tready), 64'd0);

        // Partial keep, then abort with a beat
        arm();
        chk("pk.ovf_clr", 64'(overflow), 64'd0);
        chk("pk.count_clr", 64'(count), 64'd0);
        beat(64'hA0, 8'h0F, 1'b0);
        chk_wr("pk.b0", 4'd0, 64'hA0, 8'h0F);
        beat(64'hB1, 8'h00, 1'b0);
        chk_wr("pk.b1", 4'd1, 64'hB1, 8'h00);
        abort = 1'b1;
        beat(64'hC2, 8'hFF, 1'b0);
        abort = 1'b0;
        chk_wr("pk.b2", 4'd2, 64'hC2, 8'hFF);
        chk("pk.busy", 64'(busy), 64'd0);
        chk("pk.done", 64'(done), 64'd0);
        chk("pk.count", 64'(count), 64'd3);
        chk("pk.tready", 64'(s_axis_if.tready), 64'd0);
        tick();
        chk("pk.done_after", 64'(done), 64'd0);
        chk_nowr("pk.after");
        chk("pk.count_hold", 64'(count), 64'd3);

        // Asynchronous reset mid-frame
        arm();
        beat(64'hD0, 8'hFF, 1'b0);
        beat(64'hD1, 8'hFF, 1'b0);
        chk("ar.pre_count", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        chk_reset_vals("ar");
        #1;
        rst = 1'b0;
        arm();
        beat(64'h77, 8'hFF, 1'b1);
        chk_wr("ar.new", 4'd0, 64'h77, 8'hFF);
        chk("ar.count", 64'(count), 64'd1);
        chk("ar.done", 64'(done), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
